two_input_gate_emulator: RTL and testbench

TWO_INPUT_GATE_EMULATOR -- requirements
Module: two_input_gate_emulator

---
 rtl/two_input_gate_emulator.sv | 173 +++++++++++++++++
 tb/tb_two_input_gate_emulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/two_input_gate_emulator.sv
// Emulates four identical two-input gates with a programmable propagation
// delay, selectable logic function and per-gate fault injection.
module two_input_gate_emulator #(
    parameter int unsigned DELAY_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       A1,
    input  logic       A2,
    input  logic       A3,
    input  logic       A4,
    input  logic       B1,
    input  logic       B2,
    input  logic       B3,
    input  logic       B4,
    input  logic [2:0] gateSelect,
    input  logic [3:0] fault_mask,
    input  logic [1:0] fault_type,
    output logic       op1,
    output logic       op2,
    output logic       op3,
    output logic       op4,
    output logic       settled,
    output logic [7:0] pattern_count
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned VEC_W   = 8;
    localparam int unsigned N_GATES = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] PC_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLING = 2'd1,
        ST_STABLE   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]   in_q, in_d;
    logic [N_GATES-1:0] ops_q, ops_d;
    logic               settled_q, settled_d;
    logic [CNT_W-1:0]   pc_q, pc_d;
    logic [N_GATES-1:0] f_c;
    logic               change_c;

    // Selected two-input logic function; unused encodings give 0.
    function automatic logic gate_fn(input logic [2:0] sel, input logic a, input logic b);
        logic r;
        case (sel)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = ~(a & b);
            3'b011:  r = ~(a | b);
            3'b100:  r = a ^ b;
            3'b101:  r = ~(a ^ b);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Fault overlay applied only to gates flagged as faulty.
    function automatic logic fault_fn(input logic v, input logic faulty, input logic [1:0] ft);
        logic r;
        r = v;
        if (faulty) begin
            case (ft)
                2'b01:   r = 1'b0;
                2'b10:   r = 1'b1;
                2'b11:   r = ~v;
                default: r = v;
            endcase
        end
        return r;
    endfunction

    // Live input vector and change detect against the previous sample.
    always_comb begin
        in_d     = {B4, A4, B3, A3, B2, A2, B1, A1};
        change_c = (in_d != in_q);
    end

    // Gate outputs computed from the registered inputs.
    always_comb begin
        f_c = '0;
        for (int n = 0; n < int'(N_GATES); n++) begin
            f_c[n] = fault_fn(gate_fn(gateSelect, in_q[2*n], in_q[2*n+1]),
                              fault_mask[n], fault_type);
        end
    end

    // Next-state and output logic: enable=0 beats change, change beats count.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ops_d     = ops_q;
        settled_d = settled_q;
        pc_d      = pc_q;

        if (!enable) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            ops_d     = '0;
            settled_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_SETTLING;
                    cnt_d     = '0;
                    settled_d = 1'b0;
                end
                ST_SETTLING: begin
                    if (change_c) begin
                        cnt_d = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = ST_STABLE;
                        ops_d     = f_c;
                        settled_d = 1'b1;
                        if (pc_q != PC_MAX) begin
                            pc_d = pc_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_STABLE: begin
                    if (change_c) begin
                        state_d   = ST_SETTLING;
                        cnt_d     = '0;
                        settled_d = 1'b0;
                    end else begin
                        ops_d = f_c;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    ops_d     = '0;
                    settled_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            in_q      <= '0;
            ops_q     <= '0;
            settled_q <= 1'b0;
            pc_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_q      <= in_d;
            ops_q     <= ops_d;
            settled_q <= settled_d;
            pc_q      <= pc_d;
        end
    end

    assign op1           = ops_q[0];
    assign op2           = ops_q[1];
    assign op3           = ops_q[2];
    assign op4           = ops_q[3];
    assign settled       = settled_q;
    assign pattern_count = pc_q;

endmodule

// File: tb/tb_two_input_gate_emulator.sv
// Scoreboard bench for two_input_gate_emulator with DELAY_CYCLES=4.
module tb_two_input_gate_emulator;

    localparam int unsigned DELAY = 4;

    typedef struct packed {
        logic [3:0] ops;
        logic       settled;
        logic [7:0] pc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] vec;
    logic [2:0] gs;
    logic [3:0] fmask;
    logic [1:0] ftype;
    logic       op1, op2, op3, op4;
    logic       settled;
    logic [7:0] pattern_count;

    exp_t       sb_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_ops;
    logic [7:0] exp_pc;

    always #5 clk = ~clk;

    two_input_gate_emulator #(.DELAY_CYCLES(DELAY)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .A1           (vec[0]),
        .B1           (vec[1]),
        .A2           (vec[2]),
        .B2           (vec[3]),
        .A3           (vec[4]),
        .B3           (vec[5]),
        .A4           (vec[6]),
        .B4           (vec[7]),
        .gateSelect   (gs),
        .fault_mask   (fmask),
        .fault_type   (ftype),
        .op1          (op1),
        .op2          (op2),
        .op3          (op3),
        .op4          (op4),
        .settled      (settled),
        .pattern_count(pattern_count)
    );

    // Compare one observed value against its expectation.
    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference gate function from the function table.
    function automatic logic [3:0] golden(input logic [7:0] v, input logic [2:0] sel,
                                          input logic [3:0] m, input logic [1:0] ft);
        logic [3:0] r;
        logic a, b, g;
        for (int n = 0; n < 4; n++) begin
            a = v[2*n];
            b = v[2*n+1];
            case (sel)
                3'd0:    g = a & b;
                3'd1:    g = a | b;
                3'd2:    g = !(a && b);
                3'd3:    g = !(a || b);
                3'd4:    g = a != b;
                3'd5:    g = a == b;
                default: g = 1'b0;
            endcase
            if (m[n]) begin
                if (ft == 2'b01) g = 1'b0;
                else if (ft == 2'b10) g = 1'b1;
                else if (ft == 2'b11) g = !g;
            end
            r[n] = g;
        end
        return r;
    endfunction

    // Push the expectation for the next edge, clock once, pop and compare.
    task automatic tick(input logic [3:0] e_ops, input logic e_set, input logic [7:0] e_pc);
        exp_t e;
        e.ops     = e_ops;
        e.settled = e_set;
        e.pc      = e_pc;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_eq("ops", 8'({op4, op3, op2, op1}), 8'(e.ops));
        check_eq("settled", 8'(settled), 8'(e.settled));
        check_eq("pattern_count", pattern_count, e.pc);
    endtask

    // Drive a vector and walk through a full settling window.
    task automatic settle_to(input logic [7:0] v);
        vec = v;
        repeat (DELAY) tick(exp_ops, 1'b0, exp_pc);
        exp_ops = golden(vec, gs, fmask, ftype);
        exp_pc  = (exp_pc == 8'd255) ? 8'd255 : exp_pc + 8'd1;
        tick(exp_ops, 1'b1, exp_pc);
    endtask

    // One STABLE cycle: outputs follow the current controls after one edge.
    task automatic stable_tick();
        exp_ops = golden(vec, gs, fmask, ftype);
        tick(exp_ops, 1'b1, exp_pc);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; enable = 1'b0; vec = 8'h00;
        gs = 3'b000; fmask = 4'b0000; ftype = 2'b00;
        exp_ops = 4'h0; exp_pc = 8'd0;
        tick(4'h0, 1'b0, 8'd0);
        tick(4'h0, 1'b0, 8'd0);

        // First settle out of IDLE: AND of all ones.
        rst = 1'b0; enable = 1'b1;
        settle_to(8'hFF);
        check_eq("first_settle_pc", pattern_count, 8'd1);
        stable_tick();

        // Switch to NAND in STABLE, then drop all B: hold 0, then 1.
        gs = 3'b010;
        stable_tick();
        settle_to(8'h55);
        check_eq("nand_settle_pc", pattern_count, 8'd2);

        // Toggle every two cycles: no update, settled low throughout.
        for (int k = 0; k < 5; k++) begin
            vec = (k % 2 == 1) ? 8'h55 : 8'hFF;
            tick(exp_ops, 1'b0, exp_pc);
            tick(exp_ops, 1'b0, exp_pc);
        end
        tick(exp_ops, 1'b0, exp_pc);
        tick(exp_ops, 1'b0, exp_pc);
        exp_ops = golden(vec, gs, fmask, ftype);
        exp_pc  = exp_pc + 8'd1;
        tick(exp_ops, 1'b1, exp_pc);

        // A change landing on the would-be update edge restarts the count.
        gs  = 3'b001;
        vec = 8'h00;
        repeat (DELAY) tick(exp_ops, 1'b0, exp_pc);
        settle_to(8'hAA);

        // Distinct (A,B) per gate, sweep every function code.
        settle_to(8'hE4);
        for (int s = 0; s < 8; s++) begin
            gs = 3'(s);
            stable_tick();
        end

        // XOR with inverted faults on gates 1 and 3, then other fault types.
        gs = 3'b100;
        settle_to(8'h55);
        fmask = 4'b0101; ftype = 2'b11;
        stable_tick();
        check_eq("xor_inverted", 8'({op4, op3, op2, op1}), 8'b0000_1010);
        ftype = 2'b01;
        stable_tick();
        ftype = 2'b10;
        stable_tick();
        ftype = 2'b00;
        stable_tick();
        fmask = 4'b0000;

        // Disable in STABLE: outputs clear, count held; re-enable settles again.
        enable = 1'b0;
        exp_ops = 4'h0;
        tick(4'h0, 1'b0, exp_pc);
        tick(4'h0, 1'b0, exp_pc);
        enable = 1'b1;
        settle_to(vec);

        // Reset at cnt=2 aborts settling and clears the count.
        vec = 8'hFF;
        repeat (3) tick(exp_ops, 1'b0, exp_pc);
        rst = 1'b1; gs = 3'b000;
        exp_ops = 4'h0; exp_pc = 8'd0;
        tick(4'h0, 1'b0, 8'd0);
        rst = 1'b0;
        settle_to(8'hFF);

        // Saturation of pattern_count after 300 settlings.
        for (int i = 0; i < 300; i++) begin
            settle_to((i % 2 == 0) ? 8'h55 : 8'hFF);
        end
        check_eq("pc_saturated", pattern_count, 8'd255);
        enable = 1'b0;
        exp_ops = 4'h0;
        tick(4'h0, 1'b0, 8'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
